// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main control and the ALU control decoder.
// Opcodes, ALU-op encodings, state encodings and datapath mux selects.
package mips_ctrl_pkg;

    localparam int STATE_W_DEF = 4;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // 3-bit ALU-op interface towards the ALU control decoder
    localparam logic [2:0] ALU_OP_IDLE   = 3'b000;
    localparam logic [2:0] ALU_OP_AND    = 3'b001;
    localparam logic [2:0] ALU_OP_BRANCH = 3'b010;
    localparam logic [2:0] ALU_OP_MEM    = 3'b011;
    localparam logic [2:0] ALU_OP_ADD    = 3'b100;
    localparam logic [2:0] ALU_OP_OR     = 3'b101;
    localparam logic [2:0] ALU_OP_LUI    = 3'b110;
    localparam logic [2:0] ALU_OP_RTYPE  = 3'b111;

    localparam logic [1:0] JMP_CTL_JR = 2'b10;

    // datapath mux selects
    localparam logic       SRC_A_PC      = 1'b0;
    localparam logic       SRC_A_REG     = 1'b1;
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LW,
        CLS_SW,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_JAL
    } instr_cls_e;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface multicycle_main_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode_i;
    logic [1:0]         jmp_ctl_i;
    logic               mem_ready_i;
    logic [2:0]         alu_op_o;
    logic               alu_src_a_o;
    logic [1:0]         alu_src_b_o;
    logic [1:0]         pc_src_o;
    logic               pc_write_o;
    logic               pc_write_cond_o;
    logic               branch_ne_o;
    logic               i_or_d_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic               ir_write_o;
    logic               reg_write_o;
    logic [1:0]         reg_dst_o;
    logic [1:0]         mem_to_reg_o;
    logic               illegal_op_o;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  opcode_i, jmp_ctl_i, mem_ready_i,
        output alu_op_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_write_o,
               pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, illegal_op_o,
               state_o
    );

    modport slave (
        output opcode_i, jmp_ctl_i, mem_ready_i,
        input  alu_op_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_write_o,
               pc_write_cond_o, branch_ne_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, illegal_op_o,
               state_o
    );
endinterface

// File: rtl/control_opcode_decode.sv
// Opcode classifier: instruction class, ALU op for I-type arithmetic, legal flag.
// JAL is only recognised when MULTICYCLE_CTRL_JAL_EN is defined.
module control_opcode_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  opcode_i,
    output instr_cls_e  cls_o,
    output logic [2:0]  imm_alu_op_o,
    output logic        legal_o
);

    // classify the opcode; anything not listed is illegal
    always_comb begin
        cls_o        = CLS_ILLEGAL;
        imm_alu_op_o = ALU_OP_ADD;
        legal_o      = 1'b1;
        case (opcode_i)
            OP_RTYPE: cls_o = CLS_RTYPE;
            OP_ADDI: begin
                cls_o        = CLS_ITYPE;
                imm_alu_op_o = ALU_OP_ADD;
            end
            OP_ORI: begin
                cls_o        = CLS_ITYPE;
                imm_alu_op_o = ALU_OP_OR;
            end
            OP_ANDI: begin
                cls_o        = CLS_ITYPE;
                imm_alu_op_o = ALU_OP_AND;
            end
            OP_LUI: begin
                cls_o        = CLS_ITYPE;
                imm_alu_op_o = ALU_OP_LUI;
            end
            OP_LW:   cls_o = CLS_LW;
            OP_SW:   cls_o = CLS_SW;
            OP_BEQ,
            OP_BNE:  cls_o = CLS_BRANCH;
            OP_J:    cls_o = CLS_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
            OP_JAL:  cls_o = CLS_JAL;
`else
            // without JAL support 000011 falls through to the illegal default
`endif
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM; drives ALU op and all datapath enables.
// Optional JAL support under macro MULTICYCLE_CTRL_JAL_EN.
//
// state     | meaning
// IDLE      | after reset, everything off
// FETCH     | read instruction at PC, PC+4 into PC once memory is ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | A + sign-ext imm for lw/sw
// MEM_READ  | data read at ALUOut, wait for ready
// MEM_WB    | MDR into rt
// MEM_WRITE | data write at ALUOut, wait for ready
// EXECUTE   | R-type ALU operation, JR resolved here
// R_WB      | ALUOut into rd
// I_EXEC    | I-type ALU operation
// I_WB      | ALUOut into rt
// BRANCH    | compare and conditional PC write
// JUMP      | jump target into PC
// JAL       | jump target into PC, PC into $ra
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_main_control_if.master  bus
);

    state_e      state_q, state_d;
    instr_cls_e  op_cls;
    logic [2:0]  imm_alu_op;
    logic        op_legal;

    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        illegal_op;

    control_opcode_decode u_decode (
        .opcode_i     (bus.opcode_i),
        .cls_o        (op_cls),
        .imm_alu_op_o (imm_alu_op),
        .legal_o      (op_legal)
    );

    // state register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next state and per-state datapath controls
    always_comb begin
        state_d       = state_q;
        alu_op        = ALU_OP_IDLE;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_REG;
        pc_src        = PC_SRC_ALU;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = REG_DST_RT;
        mem_to_reg    = M2R_ALUOUT;
        illegal_op    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_OP_ADD;
                if (bus.mem_ready_i) begin
                    pc_write = 1'b1;
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
                alu_op    = ALU_OP_ADD;
                if (!op_legal) begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    case (op_cls)
                        CLS_RTYPE:  state_d = S_EXECUTE;
                        CLS_ITYPE:  state_d = S_I_EXEC;
                        CLS_LW,
                        CLS_SW:     state_d = S_MEM_ADDR;
                        CLS_BRANCH: state_d = S_BRANCH;
                        CLS_JUMP:   state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
                        CLS_JAL:    state_d = S_JAL;
`else
                        // JAL is never reported as legal in this build
`endif
                        default:    state_d = S_FETCH;
                    endcase
                end
            end
            S_EXECUTE: begin
                alu_src_a = SRC_A_REG;
                alu_op    = ALU_OP_RTYPE;
                if (bus.jmp_ctl_i == JMP_CTL_JR) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_REG;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = REG_DST_RD;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                alu_op    = imm_alu_op;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_MEM;
                state_d   = (op_cls == CLS_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready_i) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = SRC_A_REG;
                alu_op        = ALU_OP_BRANCH;
                pc_src        = PC_SRC_ALUOUT;
                pc_write_cond = 1'b1;
                branch_ne     = (bus.opcode_i == OP_BNE);
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
                state_d  = S_FETCH;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REG_DST_RA;
                mem_to_reg = M2R_PC;
                state_d    = S_FETCH;
            end
`else
            // S_JAL is unreachable without JAL support
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.alu_op_o        = alu_op;
    assign bus.alu_src_a_o     = alu_src_a;
    assign bus.alu_src_b_o     = alu_src_b;
    assign bus.pc_src_o        = pc_src;
    assign bus.pc_write_o      = pc_write;
    assign bus.pc_write_cond_o = pc_write_cond;
    assign bus.branch_ne_o     = branch_ne;
    assign bus.i_or_d_o        = i_or_d;
    assign bus.mem_read_o      = mem_read;
    assign bus.mem_write_o     = mem_write;
    assign bus.ir_write_o      = ir_write;
    assign bus.reg_write_o     = reg_write;
    assign bus.reg_dst_o       = reg_dst;
    assign bus.mem_to_reg_o    = mem_to_reg;
    assign bus.illegal_op_o    = illegal_op;
    assign bus.state_o         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control: per-instruction cycle model
// built from the instruction-level behaviour, random stalls and random ignored inputs.
module tb_multicycle_main_control;

    typedef struct packed {
        logic [3:0] state;
        logic [2:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       pc_wc;
        logic       bne;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       ill;
    } exp_vec_t;

    typedef struct {
        exp_vec_t v;
        logic     rdy;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    cyc_t q[$];

    multicycle_main_control_if bus ();

    multicycle_main_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_vec_t sample();
        exp_vec_t o;
        o.state    = bus.state_o;
        o.alu_op   = bus.alu_op_o;
        o.src_a    = bus.alu_src_a_o;
        o.src_b    = bus.alu_src_b_o;
        o.pc_src   = bus.pc_src_o;
        o.pc_write = bus.pc_write_o;
        o.pc_wc    = bus.pc_write_cond_o;
        o.bne      = bus.branch_ne_o;
        o.iord     = bus.i_or_d_o;
        o.mrd      = bus.mem_read_o;
        o.mwr      = bus.mem_write_o;
        o.irw      = bus.ir_write_o;
        o.rw       = bus.reg_write_o;
        o.rdst     = bus.reg_dst_o;
        o.m2r      = bus.mem_to_reg_o;
        o.ill      = bus.illegal_op_o;
        return o;
    endfunction

    function automatic exp_vec_t z(input logic [3:0] st);
        exp_vec_t v;
        v = '0;
        v.state = st;
        return v;
    endfunction

    function automatic logic legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02: return 1'b1;
`ifdef MULTICYCLE_CTRL_JAL_EN
            6'h03: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add_cyc(input exp_vec_t v, input logic rdy);
        cyc_t c;
        c.v   = v;
        c.rdy = rdy;
        q.push_back(c);
    endtask

    // expected cycle-by-cycle outputs of one instruction, FETCH through its last state
    task automatic model_instr(input logic [5:0] op, input logic [1:0] jc, input int fst, input int mst);
        exp_vec_t v;
        for (int i = 0; i <= fst; i++) begin
            v = z(4'd1); v.mrd = 1; v.src_b = 2'b01; v.alu_op = 3'b100;
            if (i == fst) begin v.pc_write = 1; v.irw = 1; end
            add_cyc(v, i == fst);
        end
        v = z(4'd2); v.src_b = 2'b11; v.alu_op = 3'b100; v.ill = !legal(op);
        add_cyc(v, rnd_bit());
        case (op)
            6'h00: begin
                v = z(4'd7); v.src_a = 1; v.alu_op = 3'b111;
                if (jc == 2'b10) begin
                    v.pc_write = 1; v.pc_src = 2'b11;
                    add_cyc(v, rnd_bit());
                end else begin
                    add_cyc(v, rnd_bit());
                    v = z(4'd8); v.rw = 1; v.rdst = 2'b01;
                    add_cyc(v, rnd_bit());
                end
            end
            6'h08, 6'h0d, 6'h0c, 6'h0f: begin
                v = z(4'd9); v.src_a = 1; v.src_b = 2'b10;
                v.alu_op = (op == 6'h08) ? 3'b100 : (op == 6'h0d) ? 3'b101 :
                           (op == 6'h0c) ? 3'b001 : 3'b110;
                add_cyc(v, rnd_bit());
                v = z(4'd10); v.rw = 1;
                add_cyc(v, rnd_bit());
            end
            6'h23, 6'h2b: begin
                v = z(4'd3); v.src_a = 1; v.src_b = 2'b10; v.alu_op = 3'b011;
                add_cyc(v, rnd_bit());
                for (int i = 0; i <= mst; i++) begin
                    v = (op == 6'h23) ? z(4'd4) : z(4'd6);
                    v.iord = 1;
                    if (op == 6'h23) v.mrd = 1; else v.mwr = 1;
                    add_cyc(v, i == mst);
                end
                if (op == 6'h23) begin
                    v = z(4'd5); v.rw = 1; v.m2r = 2'b01;
                    add_cyc(v, rnd_bit());
                end
            end
            6'h04, 6'h05: begin
                v = z(4'd11); v.src_a = 1; v.alu_op = 3'b010; v.pc_src = 2'b01;
                v.pc_wc = 1; v.bne = (op == 6'h05);
                add_cyc(v, rnd_bit());
            end
            6'h02: begin
                v = z(4'd12); v.pc_write = 1; v.pc_src = 2'b10;
                add_cyc(v, rnd_bit());
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            6'h03: begin
                v = z(4'd13); v.pc_write = 1; v.pc_src = 2'b10;
                v.rw = 1; v.rdst = 2'b10; v.m2r = 2'b10;
                add_cyc(v, rnd_bit());
            end
`endif
            default: ;
        endcase
    endtask

    // play queued cycles (all when limit < 0), checking outputs before each edge
    task automatic run_queue(input string name, input logic [5:0] op, input logic [1:0] jc, input int limit);
        cyc_t     c;
        exp_vec_t obs;
        int       n = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            c = q.pop_front();
            bus.mem_ready_i = c.rdy;
            bus.opcode_i    = op;
            bus.jmp_ctl_i   = jc;
            #1;
            obs = sample();
            checks++;
            if (obs !== c.v) begin
                failures++;
                $display("FAIL %s cyc%0d op=%h jc=%b got=%h exp=%h", name, n, op, jc, obs, c.v);
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] op, input logic [1:0] jc,
                             input int fst, input int mst);
        model_instr(op, jc, fst, mst);
        run_queue(name, op, jc, -1);
        bus.mem_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.state_o !== 4'd1) begin
            failures++;
            $display("FAIL %s_end_in_fetch got=%0d exp=1", name, bus.state_o);
        end
    endtask

    task automatic test_reset();
        exp_vec_t obs;
        exp_vec_t f;
        reset = 1'b0;
        bus.mem_ready_i = 1'b0;
        bus.opcode_i = 6'h00;
        bus.jmp_ctl_i = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        obs = sample();
        checks++;
        if (obs !== z(4'd0)) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", obs, z(4'd0));
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        f = z(4'd1); f.mrd = 1; f.src_b = 2'b01; f.alu_op = 3'b100;
        obs = sample();
        checks++;
        if (obs !== f) begin
            failures++;
            $display("FAIL reset_release_fetch got=%h exp=%h", obs, f);
        end
        // sw stalled in MEM_WRITE, then reset held low 3 cycles with ready high
        model_instr(6'h2b, 2'b00, 0, 5);
        run_queue("reset_sw_prefix", 6'h2b, 2'b00, 4);
        q.delete();
        reset = 1'b0;
        bus.mem_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk); #1;
            obs = sample();
            checks++;
            if (obs !== z(4'd0)) begin
                failures++;
                $display("FAIL reset_mid_write cyc%0d got=%h exp=%h", i, obs, z(4'd0));
            end
        end
        reset = 1'b1;
        bus.mem_ready_i = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        obs = sample();
        checks++;
        if (obs !== f) begin
            failures++;
            $display("FAIL reset_mid_release_fetch got=%h exp=%h", obs, f);
        end
    endtask

    task automatic test_rtype();
        run_instr("add", 6'h00, 2'b00, 0, 0);
        run_instr("rtype_jc11", 6'h00, 2'b11, 1, 0);
    endtask

    task automatic test_jr();
        run_instr("jr", 6'h00, 2'b10, 0, 0);
    endtask

    task automatic test_lw_stall();
        run_instr("lw_stall", 6'h23, 2'b00, 2, 2);
        run_instr("lw", 6'h23, 2'b00, 0, 0);
        run_instr("sw_stall", 6'h2b, 2'b00, 1, 3);
    endtask

    task automatic test_itype();
        run_instr("addi", 6'h08, 2'b10, 0, 0);
        run_instr("ori", 6'h0d, 2'b00, 0, 0);
        run_instr("andi", 6'h0c, 2'b01, 0, 0);
        run_instr("lui", 6'h0f, 2'b00, 0, 0);
    endtask

    task automatic test_branch_jump();
        run_instr("bne", 6'h05, 2'b00, 0, 0);
        run_instr("beq", 6'h04, 2'b10, 0, 0);
        run_instr("j", 6'h02, 2'b00, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_3f", 6'h3f, 2'b00, 0, 0);
        run_instr("jal_op", 6'h03, 2'b00, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[11] = '{6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
        logic [5:0] op;
        logic [1:0] jc;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 10)];
            end
            jc = 2'($urandom);
            model_instr(op, jc, $urandom_range(0, 3), $urandom_range(0, 3));
            run_queue("random", op, jc, -1);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_jr();
        test_lw_stall();
        test_itype();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
